// File: rtl/lut_loader_if.sv
// rtl/lut_loader_if.sv - Loader/read bus bundle for the lut_loader table
//
// Signals:
//   start   : one-cycle pulse that begins a full-table load
//   indata  : load byte stream (8 bits)
//   invalid : indata is valid this cycle
//   inready : loader accepts a byte this cycle (transfer = invalid & inready)
//   busy    : load in progress
//   done    : one-cycle pulse after the last entry is written
//   index   : read address from fetch/branch logic (4 bits)
//   out     : table[index], combinational read (10 bits)
// Modports:
//   master : byte source / reader side
//   slave  : the lut_loader table
interface lut_loader_if;
  logic       start;
  logic [7:0] indata;
  logic       invalid;
  logic       inready;
  logic       busy;
  logic       done;
  logic [3:0] index;
  logic [9:0] out;

  modport master (
    output start, indata, invalid, index,
    input  inready, busy, done, out
  );

  modport slave (
    input  start, indata, invalid, index,
    output inready, busy, done, out
  );
endinterface

// File: rtl/lut_loader.sv
// rtl/lut_loader.sv - Writable 16x10 PC-target / data-address table with byte-stream loader
//
// Ports:
//   clk : system clock, all state updates on the rising edge
//   rst : asynchronous, active-high reset (table back to all 10'd1, FSM idle)
//   bus : lut_loader_if.slave
//         start/indata/invalid in, inready/busy/done out (loader side)
//         index in, out out (combinational read side)
//
// A load consumes exactly 32 bytes: for each entry 0..15 a low byte (bits 7:0)
// then a high byte whose bits 1:0 become entry bits 9:8.
module lut_loader (
  input  logic           clk,
  input  logic           rst,
  lut_loader_if.slave    bus
);

  localparam int ENTRIES = 16;
  localparam int WIDTH   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       ptr;
  logic [7:0]       low;
  logic [WIDTH-1:0] tbl [ENTRIES];
  logic             xfer;

  assign xfer = bus.invalid & bus.inready;

  // Read port: the old value is seen during the write cycle because the
  // table only changes on the clock edge.
  assign bus.out = tbl[bus.index];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so a pulse during a
  // load or in FIN does not restart anything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = LO;
      LO:   if (xfer)      state_nxt = HI;
      HI:   if (xfer)      state_nxt = (ptr == 4'd15) ? FIN : LO;
      FIN:                 state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.inready = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state)
      LO, HI: begin
        bus.inready = 1'b1;
        bus.busy    = 1'b1;
      end
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: pointer, low-byte holding register and the table itself.
  // The pointer stops at 15 on the final write instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 4'd0;
      low <= 8'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= WIDTH'(1);
      end
    end else begin
      if (state == IDLE && bus.start) begin
        ptr <= 4'd0;
      end
      if (state == LO && xfer) begin
        low <= bus.indata;
      end
      if (state == HI && xfer) begin
        tbl[ptr] <= {bus.indata[1:0], low};
        if (ptr != 4'd15) begin
          ptr <= ptr + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_loader.sv
// tb/tb_lut_loader.sv - Directed self-checking bench for lut_loader
module tb_lut_loader;

  logic clk;
  logic rst;
  lut_loader_if bus ();

  lut_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [9:0] exp_tbl [16];
  logic [9:0] ld_vals [16];
  logic [5:0] hi_junk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.index = 4'(i);
      #1;
      chk(tag, {22'd0, bus.out}, {22'd0, exp_tbl[i]});
    end
  endtask

  // Runs a load of nbytes transfers from ld_vals. gap: random idle cycles
  // between bytes; start_at: byte number at which start is re-pulsed;
  // watch3: check entry 3 around its write.
  task automatic do_load(input bit gap, input int start_at, input int nbytes, input bit watch3);
    int e;
    int g;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    for (int b = 0; b < nbytes; b++) begin
      e = b / 2;
      if (gap) begin
        g = 0;
        while (g < 4 && $urandom_range(0, 1) == 1) begin
          bus.invalid = 1'b0;
          @(posedge clk); #1;
          chk("busy_gap", {31'd0, bus.busy}, 32'd1);
          g++;
        end
      end
      bus.indata  = (b % 2 == 1) ? {hi_junk, ld_vals[e][9:8]} : ld_vals[e][7:0];
      bus.invalid = 1'b1;
      bus.start   = (b == start_at);
      chk("inready", {31'd0, bus.inready}, 32'd1);
      if (watch3 && b == 7) begin
        bus.index = 4'd3;
        #1;
        chk("e3_old_in_write_cycle", {22'd0, bus.out}, {22'd0, exp_tbl[3]});
      end
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.invalid = 1'b0;
      if (b % 2 == 1) exp_tbl[e] = ld_vals[e];
      if (watch3 && b == 7) begin
        chk("e3_new_next_cycle", {22'd0, bus.out}, {22'd0, exp_tbl[3]});
      end
      if (b < 31) begin
        chk("busy_mid", {31'd0, bus.busy}, 32'd1);
        chk("done_early", {31'd0, bus.done}, 32'd0);
      end
    end
    if (nbytes == 32) begin
      chk("done_pulse", {31'd0, bus.done}, 32'd1);
      chk("busy_in_fin", {31'd0, bus.busy}, 32'd0);
      chk("inready_in_fin", {31'd0, bus.inready}, 32'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
      chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.indata  = 8'd0;
    bus.invalid = 1'b0;
    bus.index   = 4'd0;
    hi_junk     = 6'd0;
    for (int i = 0; i < 16; i++) exp_tbl[i] = 10'd1;

    // Reset state, with start held during reset (reset wins)
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_inready", {31'd0, bus.inready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    check_table("rst_table");
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Back-to-back load: entry i = 3F0+i, high byte 8'h03
    for (int i = 0; i < 16; i++) ld_vals[i] = 10'h3F0 + 10'(i);
    do_load(1'b0, -1, 32, 1'b0);
    bus.index = 4'd5; #1;
    chk("idx5_3f5", {22'd0, bus.out}, 32'h3F5);
    bus.index = 4'd0; #1;
    chk("idx0_3f0", {22'd0, bus.out}, 32'h3F0);
    check_table("load1_table");

    // Same load with random valid gaps, from reset contents
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_tbl[i] = 10'd1;
    @(posedge clk); #1;
    do_load(1'b1, -1, 32, 1'b0);
    check_table("gap_table");

    // Entry 3 = 26C via high byte FE (upper six bits ignored); others 155+i
    for (int i = 0; i < 16; i++) ld_vals[i] = 10'h155 + 10'(i);
    ld_vals[3] = 10'h26C;
    hi_junk = 6'h3F;
    do_load(1'b0, -1, 32, 1'b1);
    check_table("e3_table");

    // Reset after 11 bytes: table back to all ones immediately
    for (int i = 0; i < 16; i++) ld_vals[i] = 10'h2A0 + 10'(i);
    hi_junk = 6'h15;
    do_load(1'b0, -1, 11, 1'b0);
    bus.index = 4'd4; #1;
    chk("partial_e4", {22'd0, bus.out}, 32'h2A4);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) exp_tbl[i] = 10'd1;
    chk("async_rst_e4", {22'd0, bus.out}, 32'd1);
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_rst_inready", {31'd0, bus.inready}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_table("abort_table");
    do_load(1'b0, -1, 32, 1'b0);
    check_table("reload_table");

    // Start pulsed at byte 7 mid-load: ignored, load runs to 32 transfers
    for (int i = 0; i < 16; i++) ld_vals[i] = 10'h0C0 + 10'(i * 3);
    hi_junk = 6'h2A;
    do_load(1'b0, 7, 32, 1'b0);
    check_table("restart_ignored_table");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Writable 16-entry x 10-bit PC-target / data-address table for the 3BC processor; replaces the hard-coded lookup so a program's offsets can be loaded at runtime.
- A byte-stream loader (writer side) fills the table from a testbench or boot source over a valid/ready handshake.
- The fetch/branch logic reads it combinationally through the same Index→Out interface the processor already uses.

Parameters:
- ENTRIES, 16, number of table entries (Index width = 4; fixed at 16 for this design)
- WIDTH, 10, entry width in bits (two's-complement offset or absolute address)

Ports:
- Clk  input  1  system clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle pulse; begins a full-table load at entry 0
- InData  input  8  load byte stream
- InValid  input  1  InData is valid this cycle
- InReady  output  1  loader accepts a byte this cycle; transfer when InValid & InReady
- Busy  output  1  load in progress
- Done  output  1  one-cycle pulse after entry 15 is written
- Index  input  4  read address from fetch/branch logic
- Out  output  10  table[Index], combinational read

Behaviour:
- Reset (async, any state): all 16 entries = 10'd1, state IDLE, entry pointer = 0, InReady = 0, Busy = 0, Done = 0. Reset mid-load discards the partial load; the table returns to reset contents.
- Read port: Out = table[Index] combinationally, zero latency.
  - A write commits on the clock edge.
  - Same-cycle read of the entry being written returns the old value; the new value is visible the following cycle.
- FSM states: IDLE, LO, HI, FIN.
  - IDLE: InReady = 0, Busy = 0. Start=1 → LO, pointer = 0.
  - LO: InReady = 1, Busy = 1. On transfer, latch InData as bits [7:0] of a holding register → HI.
  - HI: InReady = 1, Busy = 1. On transfer, write table[pointer] = {InData[1:0], low}.
    - InData[7:2] is ignored.
    - If pointer == 15 → FIN; else pointer += 1 → LO.
  - FIN: Done = 1 for exactly one cycle, InReady = 0, Busy = 0 → IDLE.
- Without InValid, the FSM holds state indefinitely; no timeout.
- Start while Busy or in FIN is ignored (no restart).
- Start in the same cycle as Reset: Reset wins.
- Pointer does not wrap during a load; exactly 32 bytes are consumed per load.
- The table holds its contents until the next load or Reset; entries not yet rewritten during a load keep their previous values.
- Done and Busy are never high together.
- Entry width arithmetic: no sign extension inside the block; consumers interpret 10 bits as signed.

Test Plan:
- Reset, then sweep Index 0..15 → Out = 10'd1 for every index; InReady = 0, Busy = 0, Done = 0.
- Start, then 32 back-to-back bytes encoding entry i = 10'h3F0+i (low = 8'hF0+i, high = 8'h03) → Done pulses one cycle after the 32nd transfer; Out for Index 5 = 10'h3F5; Index 0 = 10'h3F0 (-16 signed).
- Same load with InValid toggling randomly (~50%) → identical final table; Busy stays high throughout; only valid&ready cycles advance.
- Write entry 3 with high byte 8'hFE, low byte 8'h6C and Index = 3 held → Out = old value in the write cycle, 10'h26C the next cycle (upper bits 7:2 ignored).
- Assert Reset after 11 bytes → table returns to all 10'd1 immediately (async), FSM = IDLE; a following Start + full load completes normally.
- Pulse Start during an active load at byte 7 → load continues uninterrupted; pointer is not reset; Done occurs after 32 total transfers.
